ap_ctrl_txn_recorder: RTL and testbench

Synthesizable transaction recorder that sits directly downstream of the ap_ctrl handshake of an HLS block (e.g. fetching_decoding_ip or one of its fetch/decode sub-functions). It taps ap_start/ap_ready/ap_done/ap_continue, timestamps each transaction, and pushes one record per completed transaction into a small FIFO. The FIFO drains over a valid/ready stream to the on-chip trace path, giving in-hardware the module-status data that simulation-only monitors capture.

---
 rtl/ap_ctrl_txn_recorder.sv | 178 +++++++++++++++++
 tb/tb_ap_ctrl_txn_recorder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ap_ctrl_txn_recorder.sv
// Records one {txn_id, start_ts, latency} entry per completed ap_ctrl transaction
// into a small FIFO drained over a valid/ready stream.
module ap_ctrl_txn_recorder #(
  parameter int TS_W  = 32,
  parameter int ID_W  = 16,
  parameter int DEPTH = 8
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic                   clr,
  input  logic                   en,
  input  logic                   mon_ap_start,
  input  logic                   mon_ap_ready,
  input  logic                   mon_ap_done,
  input  logic                   mon_ap_continue,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic [ID_W+2*TS_W-1:0] rec_data,
  output logic                   busy,
  output logic [ID_W-1:0]        txn_cnt,
  output logic [15:0]            drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = ID_W + 2 * TS_W;

  typedef enum logic [0:0] {IDLE = 1'b0, RUNNING = 1'b1} state_t;

  state_t          state_r, state_nxt_s;
  logic [TS_W-1:0] ts_r, start_ts_r;
  logic [ID_W-1:0] cur_id_r, txn_cnt_r;
  logic [15:0]     drop_cnt_r;
  logic            busy_r, rec_valid_r;
  logic [RW-1:0]   rec_data_r;
  logic [RW-1:0]   mem_r [DEPTH];
  logic [AW:0]     wr_ptr_r, rd_ptr_r;

  logic            close_s, capture_s, push_s;
  logic [RW-1:0]   push_rec_s, head_nxt_s;
  logic            pop_s, full_s, wr_en_s, drop_s, empty_nxt_s;
  logic [AW:0]     wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic            ready_unused_s;

  // ap_ready is tapped for completeness only
  assign ready_unused_s = mon_ap_ready;

  // Transaction FSM: open/close decisions and the record to push
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    push_s      = 1'b0;
    push_rec_s  = {RW{1'b0}};
    close_s     = mon_ap_done && mon_ap_continue;
    case (state_r)
      IDLE: begin
        if (en && mon_ap_start) begin
          capture_s = 1'b1;
          if (close_s) begin
            push_s      = 1'b1;
            push_rec_s  = {txn_cnt_r, ts_r, {TS_W{1'b0}}};
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = RUNNING;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUNNING: begin
        if (close_s) begin
          push_s      = 1'b1;
          push_rec_s  = {cur_id_r, start_ts_r, ts_r - start_ts_r};
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RUNNING;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FIFO control; the head register is loaded from the post-update read pointer
  always_comb begin
    pop_s        = rec_valid_r && rec_ready;
    full_s       = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    wr_en_s      = push_s && (!full_s || pop_s);
    drop_s       = push_s && full_s && !pop_s;
    wr_ptr_nxt_s = wr_ptr_r + (AW+1)'(wr_en_s);
    rd_ptr_nxt_s = rd_ptr_r + (AW+1)'(pop_s);
    empty_nxt_s  = (wr_ptr_nxt_s == rd_ptr_nxt_s);
    if (empty_nxt_s) begin
      head_nxt_s = rec_data_r;
    end else if (wr_en_s && (rd_ptr_nxt_s[AW-1:0] == wr_ptr_r[AW-1:0])) begin
      head_nxt_s = push_rec_s;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s[AW-1:0]];
    end
  end

  // Timestamp, FSM state and per-transaction capture
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ts_r       <= {TS_W{1'b0}};
      state_r    <= IDLE;
      busy_r     <= 1'b0;
      start_ts_r <= {TS_W{1'b0}};
      cur_id_r   <= {ID_W{1'b0}};
    end else if (clr) begin
      ts_r       <= {TS_W{1'b0}};
      state_r    <= IDLE;
      busy_r     <= 1'b0;
      start_ts_r <= {TS_W{1'b0}};
      cur_id_r   <= {ID_W{1'b0}};
    end else begin
      ts_r    <= ts_r + TS_W'(1);
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == RUNNING);
      if (capture_s) begin
        start_ts_r <= ts_r;
        cur_id_r   <= txn_cnt_r;
      end
    end
  end

  // Completion and drop counters; drops saturate
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      txn_cnt_r  <= {ID_W{1'b0}};
      drop_cnt_r <= 16'h0000;
    end else if (clr) begin
      txn_cnt_r  <= {ID_W{1'b0}};
      drop_cnt_r <= 16'h0000;
    end else begin
      if (push_s) begin
        txn_cnt_r <= txn_cnt_r + ID_W'(1);
      end
      if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
        drop_cnt_r <= drop_cnt_r + 16'h0001;
      end
    end
  end

  // FIFO pointers and registered head
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr_r    <= {(AW+1){1'b0}};
      rd_ptr_r    <= {(AW+1){1'b0}};
      rec_valid_r <= 1'b0;
      rec_data_r  <= {RW{1'b0}};
    end else if (clr) begin
      wr_ptr_r    <= {(AW+1){1'b0}};
      rd_ptr_r    <= {(AW+1){1'b0}};
      rec_valid_r <= 1'b0;
      rec_data_r  <= {RW{1'b0}};
    end else begin
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      rec_valid_r <= !empty_nxt_s;
      rec_data_r  <= head_nxt_s;
    end
  end

  // Record storage; contents are only read behind valid pointers
  always_ff @(posedge ap_clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_rec_s;
    end
  end

  assign rec_valid = rec_valid_r;
  assign rec_data  = rec_data_r;
  assign busy      = busy_r;
  assign txn_cnt   = txn_cnt_r;
  assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_ap_ctrl_txn_recorder.sv
// Bench for ap_ctrl_txn_recorder: 32-bit and 8-bit timestamp instances checked against a
// queue-based transaction model, plus hand-derived vector table and corner sequences.
module tb_ap_ctrl_txn_recorder;

  localparam int DEPTH = 8;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n, clr, en, mon_ap_start, mon_ap_ready, mon_ap_done, mon_ap_continue, rec_ready;
  logic        rec_valid, busy, rec_valid8, busy8;
  logic [79:0] rec_data;
  logic [31:0] rec_data8;
  logic [15:0] txn_cnt, drop_cnt, txn_cnt8, drop_cnt8;

  int total = 0;
  int bad   = 0;

  ap_ctrl_txn_recorder #(.TS_W(32), .ID_W(16), .DEPTH(DEPTH)) u_dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .clr(clr), .en(en),
    .mon_ap_start(mon_ap_start), .mon_ap_ready(mon_ap_ready), .mon_ap_done(mon_ap_done),
    .mon_ap_continue(mon_ap_continue), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_data(rec_data), .busy(busy), .txn_cnt(txn_cnt), .drop_cnt(drop_cnt));

  ap_ctrl_txn_recorder #(.TS_W(8), .ID_W(16), .DEPTH(DEPTH)) u_dut8 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .clr(clr), .en(en),
    .mon_ap_start(mon_ap_start), .mon_ap_ready(mon_ap_ready), .mon_ap_done(mon_ap_done),
    .mon_ap_continue(mon_ap_continue), .rec_valid(rec_valid8), .rec_ready(rec_ready),
    .rec_data(rec_data8), .busy(busy8), .txn_cnt(txn_cnt8), .drop_cnt(drop_cnt8));

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [15:0] id;
    logic [31:0] st;
    logic [31:0] lat;
  } rec_t;

  rec_t        q[$];
  int unsigned m_ts;
  bit          m_inflight;
  logic [31:0] m_st;
  logic [15:0] m_id, m_txn, m_drop;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ts = 0;
    m_inflight = 1'b0;
    m_txn = 16'd0;
    m_drop = 16'd0;
  endtask

  // One clock edge of the transaction rules, using the inputs held during the cycle
  task automatic model_edge();
    rec_t r;
    bit   pushed = 1'b0;
    bit   pop;
    if (clr) begin
      model_reset();
      return;
    end
    pop = (q.size() > 0) && rec_ready;
    if (!m_inflight) begin
      if (en && mon_ap_start) begin
        if (mon_ap_done && mon_ap_continue) begin
          r.id = m_txn; r.st = m_ts; r.lat = 32'd0; pushed = 1'b1;
        end else begin
          m_inflight = 1'b1; m_st = m_ts; m_id = m_txn;
        end
      end
    end else if (mon_ap_done && mon_ap_continue) begin
      r.id = m_id; r.st = m_st; r.lat = m_ts - m_st; pushed = 1'b1;
      m_inflight = 1'b0;
    end
    if (pop) void'(q.pop_front());
    if (pushed) begin
      m_txn++;
      if (q.size() < DEPTH) q.push_back(r);
      else if (m_drop != 16'hFFFF) m_drop++;
    end
    m_ts++;
  endtask

  task automatic check_model();
    chk("m_valid", 80'(rec_valid), 80'(q.size() > 0));
    chk("m_valid8", 80'(rec_valid8), 80'(q.size() > 0));
    if (q.size() > 0) begin
      chk("m_data", rec_data, {q[0].id, q[0].st, q[0].lat});
      chk("m_data8", 80'(rec_data8), 80'({q[0].id, q[0].st[7:0], q[0].lat[7:0]}));
    end
    chk("m_busy", 80'(busy), 80'(m_inflight));
    chk("m_busy8", 80'(busy8), 80'(m_inflight));
    chk("m_txn", 80'(txn_cnt), 80'(m_txn));
    chk("m_txn8", 80'(txn_cnt8), 80'(m_txn));
    chk("m_drop", 80'(drop_cnt), 80'(m_drop));
    chk("m_drop8", 80'(drop_cnt8), 80'(m_drop));
  endtask

  task automatic step();
    @(posedge ap_clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic set_in(input logic c, input logic e, input logic s, input logic d,
                        input logic k, input logic r);
    clr = c; en = e; mon_ap_start = s; mon_ap_done = d; mon_ap_continue = k; rec_ready = r;
  endtask

  typedef struct {
    logic c, e, s, d, k, r;
    int   n;
    logic ev, eb;
    logic [15:0] etxn, id;
    logic [31:0] st, lat;
  } vec_t;

  function automatic vec_t mk(logic c, logic e, logic s, logic d, logic k, logic r, int n,
                              logic ev, logic eb, logic [15:0] etxn, logic [15:0] id,
                              logic [31:0] st, logic [31:0] lat);
    vec_t v;
    v.c = c; v.e = e; v.s = s; v.d = d; v.k = k; v.r = r; v.n = n;
    v.ev = ev; v.eb = eb; v.etxn = etxn; v.id = id; v.st = st; v.lat = lat;
    return v;
  endfunction

  vec_t tbl[15];
  int   exp_ids[8] = '{1, 2, 3, 4, 5, 6, 7, 10};
  int   rdy_pct;

  initial begin
    // Rows: inputs held for n cycles, then expected outputs after the last edge
    tbl[0]  = mk(0,1,0,0,0,1, 5, 0,0,0, 0, 0, 0);
    tbl[1]  = mk(0,1,1,0,0,1, 1, 0,1,0, 0, 0, 0);
    tbl[2]  = mk(0,1,0,0,0,1, 6, 0,1,0, 0, 0, 0);
    tbl[3]  = mk(0,1,0,1,1,1, 1, 1,0,1, 0, 5, 7);
    tbl[4]  = mk(1,1,0,0,0,1, 1, 0,0,0, 0, 0, 0);
    tbl[5]  = mk(0,1,0,0,0,1, 3, 0,0,0, 0, 0, 0);
    tbl[6]  = mk(0,1,1,1,1,1, 1, 1,0,1, 0, 3, 0);
    tbl[7]  = mk(0,1,1,0,0,1, 1, 0,1,1, 0, 0, 0);
    tbl[8]  = mk(0,1,1,0,0,1, 1, 0,1,1, 0, 0, 0);
    tbl[9]  = mk(0,1,1,1,1,1, 1, 1,0,2, 1, 4, 2);
    tbl[10] = mk(0,1,0,0,0,1, 1, 0,0,2, 0, 0, 0);
    tbl[11] = mk(0,1,1,0,0,1, 1, 0,1,2, 0, 0, 0);
    tbl[12] = mk(0,1,0,1,0,1, 4, 0,1,2, 0, 0, 0);
    tbl[13] = mk(0,1,0,1,1,1, 1, 1,0,3, 2, 8, 5);
    tbl[14] = mk(0,1,0,0,0,1, 1, 0,0,3, 0, 0, 0);

    ap_rst_n = 1'b0;
    mon_ap_ready = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge ap_clk);
    #1;
    chk("rst_valid", 80'(rec_valid), 80'd0);
    chk("rst_data", rec_data, 80'd0);
    chk("rst_busy", 80'(busy), 80'd0);
    chk("rst_txn", 80'(txn_cnt), 80'd0);
    chk("rst_drop", 80'(drop_cnt), 80'd0);
    ap_rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 15; i++) begin
      set_in(tbl[i].c, tbl[i].e, tbl[i].s, tbl[i].d, tbl[i].k, tbl[i].r);
      repeat (tbl[i].n) step();
      chk($sformatf("row%0d_valid", i), 80'(rec_valid), 80'(tbl[i].ev));
      chk($sformatf("row%0d_busy", i), 80'(busy), 80'(tbl[i].eb));
      chk($sformatf("row%0d_txn", i), 80'(txn_cnt), 80'(tbl[i].etxn));
      if (tbl[i].ev) chk($sformatf("row%0d_data", i), rec_data, {tbl[i].id, tbl[i].st, tbl[i].lat});
    end

    // Overflow: ten transactions with no consumer
    set_in(1, 1, 0, 0, 0, 0); step();
    for (int k = 0; k < 10; k++) begin
      set_in(0, 1, 1, 0, 0, 0); step();
      set_in(0, 1, 0, 1, 1, 0); step();
    end
    chk("ovf_drop", 80'(drop_cnt), 80'd2);
    chk("ovf_txn", 80'(txn_cnt), 80'd10);
    chk("ovf_head", 80'(rec_data[79:64]), 80'd0);
    set_in(0, 1, 1, 0, 0, 0); step();
    set_in(0, 1, 0, 1, 1, 1); step();
    chk("ovf_pushpop_drop", 80'(drop_cnt), 80'd2);
    chk("ovf_pushpop_txn", 80'(txn_cnt), 80'd11);
    set_in(0, 1, 0, 0, 0, 1);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("ovf_order%0d", j), 80'(rec_data[79:64]), 80'(exp_ids[j]));
      step();
    end
    chk("ovf_drained", 80'(rec_valid), 80'd0);

    // Timestamp wrap on the 8-bit instance: open at 250, close at 4
    set_in(1, 1, 0, 0, 0, 0); step();
    set_in(0, 1, 0, 0, 0, 0); repeat (250) step();
    set_in(0, 1, 1, 0, 0, 0); step();
    set_in(0, 1, 0, 0, 0, 0); repeat (9) step();
    set_in(0, 1, 0, 1, 1, 0); step();
    chk("wrap_rec8", 80'(rec_data8), 80'({16'd0, 8'd250, 8'd10}));
    chk("wrap_lat32", 80'(rec_data[31:0]), 80'd10);

    // clr with three queued records
    set_in(1, 1, 0, 0, 0, 0); step();
    for (int k = 0; k < 3; k++) begin
      set_in(0, 1, 1, 0, 0, 0); step();
      set_in(0, 1, 0, 1, 1, 0); step();
    end
    chk("clr_pre_txn", 80'(txn_cnt), 80'd3);
    set_in(1, 1, 0, 0, 0, 0); step();
    chk("clr_valid", 80'(rec_valid), 80'd0);
    chk("clr_txn", 80'(txn_cnt), 80'd0);
    set_in(0, 1, 0, 0, 0, 1); step();
    chk("clr_still_empty", 80'(rec_valid), 80'd0);

    // en low blocks opening
    set_in(0, 0, 1, 0, 0, 1); repeat (4) step();
    chk("en0_busy", 80'(busy), 80'd0);
    set_in(0, 0, 1, 1, 1, 1); repeat (2) step();
    chk("en0_valid", 80'(rec_valid), 80'd0);
    chk("en0_txn", 80'(txn_cnt), 80'd0);

    // Asynchronous reset while RUNNING with records queued
    for (int k = 0; k < 2; k++) begin
      set_in(0, 1, 1, 0, 0, 0); step();
      set_in(0, 1, 0, 1, 1, 0); step();
    end
    set_in(0, 1, 1, 0, 0, 0); step();
    chk("prerst_busy", 80'(busy), 80'd1);
    set_in(0, 1, 0, 0, 0, 0);
    #2;
    ap_rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", 80'(rec_valid), 80'd0);
    chk("arst_data", rec_data, 80'd0);
    chk("arst_busy", 80'(busy), 80'd0);
    chk("arst_txn", 80'(txn_cnt), 80'd0);
    chk("arst_valid8", 80'(rec_valid8), 80'd0);
    set_in(0, 1, 0, 1, 1, 0);
    @(posedge ap_clk);
    #1;
    chk("arst_hold_valid", 80'(rec_valid), 80'd0);
    ap_rst_n = 1'b1;
    set_in(0, 1, 0, 1, 1, 0); step();
    chk("arst_norec", 80'(rec_valid), 80'd0);
    chk("arst_notxn", 80'(txn_cnt), 80'd0);

    // Randomized traffic against the model, alternating consumer pressure
    rdy_pct = 90;
    for (int c = 0; c < 3000; c++) begin
      if ((c % 300) == 0) rdy_pct = (rdy_pct == 90) ? 15 : 90;
      clr             = ($urandom_range(63) == 0);
      en              = ($urandom_range(7) != 0);
      mon_ap_start    = ($urandom_range(1) == 1);
      mon_ap_done     = ($urandom_range(9) < 4);
      mon_ap_continue = ($urandom_range(9) < 7);
      mon_ap_ready    = ($urandom_range(1) == 1);
      rec_ready       = ($urandom_range(99) < rdy_pct);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
